// File: rtl/uncache_wr_buffer_if.sv
// uncache_wr_buffer_if: store-in, load-probe and bridge-write signals of the uncached posted-write buffer.
interface uncache_wr_buffer_if #(parameter int DEPTH = 4, parameter int ADDR_W = 32, parameter int DATA_W = 32);
  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(DEPTH) + 1;
  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [SW-1:0]     in_wstrb;
  logic [2:0]        in_type;
  logic              in_ready;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_stall;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [SW-1:0]     wr_wstrb;
  logic [2:0]        wr_type;
  logic              wr_rdy;
  logic              wr_done;
  logic              empty;
  logic              full;
  logic [CW-1:0]     count;
  modport slave (
    input  in_valid, in_addr, in_data, in_wstrb, in_type, rd_valid, rd_addr, wr_rdy, wr_done,
    output in_ready, rd_stall, wr_req, wr_addr, wr_data, wr_wstrb, wr_type, empty, full, count
  );
  modport master (
    output in_valid, in_addr, in_data, in_wstrb, in_type, rd_valid, rd_addr, wr_rdy, wr_done,
    input  in_ready, rd_stall, wr_req, wr_addr, wr_data, wr_wstrb, wr_type, empty, full, count
  );
endinterface

// File: rtl/uncache_wr_buffer.sv
// uncache_wr_buffer: posted-write FIFO draining uncached stores to the AXI bridge, one write in flight.
// Define UNCACHE_WB_MERGE_EN to merge same-word stores into the tail-most entry.
module uncache_wr_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic aclk,
  input logic aresetn,
  uncache_wr_buffer_if.slave bus
);
  localparam int SW = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t            r_state, w_state_n;
  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [SW-1:0]     r_wstrb [DEPTH];
  logic [2:0]        r_type  [DEPTH];
  logic [PW-1:0]     r_head, r_tail, w_last;
  logic [CW-1:0]     r_count, w_count_n;
  logic              w_full, w_merge, w_alloc, w_pop, w_hit;
  assign w_full = r_count == CW'(DEPTH);
  assign w_last = r_tail - PW'(1);
`ifdef UNCACHE_WB_MERGE_EN
  // the tail-most entry is frozen once it is the head being written out
  assign w_merge = bus.in_valid && r_count != '0 &&
                   r_addr[w_last][ADDR_W-1:2] == bus.in_addr[ADDR_W-1:2] &&
                   !(r_count == CW'(1) && r_state != IDLE);
`else
  assign w_merge = 1'b0;
`endif
  assign w_alloc   = bus.in_valid & !w_full & !w_merge;
  assign w_pop     = (r_state == WAIT) & bus.wr_done;
  assign w_count_n = r_count + CW'(w_alloc) - CW'(w_pop);
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE:    w_state_n = (r_count != '0) ? REQ : IDLE;
      REQ:     w_state_n = bus.wr_rdy ? WAIT : REQ;
      WAIT:    w_state_n = bus.wr_done ? ((w_count_n != '0) ? REQ : IDLE) : WAIT;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_state <= IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      if (w_pop) r_head <= r_head + PW'(1);
      if (w_alloc) r_tail <= r_tail + PW'(1);
    end
  always_ff @(posedge aclk) begin
    if (w_alloc) begin
      r_addr[r_tail]  <= bus.in_addr;
      r_data[r_tail]  <= bus.in_data;
      r_wstrb[r_tail] <= bus.in_wstrb;
      r_type[r_tail]  <= bus.in_type;
    end
    if (w_merge) begin
      for (int b = 0; b < SW; b++)
        if (bus.in_wstrb[b]) r_data[w_last][8*b +: 8] <= bus.in_data[8*b +: 8];
      r_wstrb[w_last] <= r_wstrb[w_last] | bus.in_wstrb;
      r_type[w_last]  <= 3'b010;
    end
  end
  // a store accepted this cycle counts as pending for the load probe
  always_comb begin
    logic [PW-1:0] off;
    w_hit = bus.in_valid & bus.in_ready & (bus.in_addr[ADDR_W-1:2] == bus.rd_addr[ADDR_W-1:2]);
    for (int i = 0; i < DEPTH; i++) begin
      off   = PW'(i) - r_head;
      w_hit = w_hit | (({1'b0, off} < r_count) & (r_addr[i][ADDR_W-1:2] == bus.rd_addr[ADDR_W-1:2]));
    end
  end
  assign bus.rd_stall = bus.rd_valid & w_hit;
  assign bus.in_ready = !w_full | w_merge;
  assign bus.wr_req   = r_state == REQ;
  assign bus.wr_addr  = bus.wr_req ? r_addr[r_head]  : '0;
  assign bus.wr_data  = bus.wr_req ? r_data[r_head]  : '0;
  assign bus.wr_wstrb = bus.wr_req ? r_wstrb[r_head] : '0;
  assign bus.wr_type  = bus.wr_req ? r_type[r_head]  : '0;
  assign bus.empty    = r_count == '0;
  assign bus.full     = w_full;
  assign bus.count    = r_count;
endmodule

// File: tb/tb_uncache_wr_buffer.sv
// tb_uncache_wr_buffer: directed self-checking bench for the uncached posted-write buffer.
module tb_uncache_wr_buffer;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   total = 0;
  int   fails = 0;
  uncache_wr_buffer_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) bus();
  uncache_wr_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));
  always #5 aclk = ~aclk;
  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] t);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_wstrb = s;
    bus.in_type  = t;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (!bus.wr_req && n < 20) begin
      tick();
      n++;
    end
    check(tag, bus.wr_req, 1'b1);
  endtask
  task automatic handshake();
    bus.wr_rdy = 1'b1;
    tick();
    bus.wr_rdy  = 1'b0;
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
  endtask
  task automatic drain(input string tag, input logic [31:0] a, input logic [31:0] d);
    int n;
    wait_req(tag, n);
    check({tag, "_addr"}, bus.wr_addr, a);
    check({tag, "_data"}, bus.wr_data, d);
    handshake();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n, seen;
    {bus.in_valid, bus.in_addr, bus.in_data, bus.in_wstrb, bus.in_type} = '0;
    {bus.rd_valid, bus.rd_addr, bus.wr_rdy, bus.wr_done} = '0;
    tick();
    tick();
    #1;
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_wr_req", bus.wr_req, 0);
    check("rst_wr_fields", {bus.wr_addr, bus.wr_data}, 64'h0);
    check("rst_wr_strb_type", {bus.wr_wstrb, bus.wr_type}, 0);
    check("rst_rd_stall", bus.rd_stall, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    // single store, same-cycle load probe sees it
    bus.in_valid = 1'b1; bus.in_addr = 32'h1FAF_F000; bus.in_data = 32'h1234_5678;
    bus.in_wstrb = 4'hF; bus.in_type = 3'd2;
    bus.rd_valid = 1'b1; bus.rd_addr = 32'h1FAF_F000;
    #1;
    check("t1_in_ready", bus.in_ready, 1);
    check("t1_stall_same_cycle", bus.rd_stall, 1);
    tick();
    bus.in_valid = 1'b0; bus.rd_valid = 1'b0;
    #1;
    check("t1_count1", bus.count, 1);
    check("t1_not_empty", bus.empty, 0);
    wait_req("t1_req", n);
    check("t1_latency", n <= 2, 1);
    check("t1_addr", bus.wr_addr, 32'h1FAF_F000);
    check("t1_data", bus.wr_data, 32'h1234_5678);
    check("t1_wstrb", bus.wr_wstrb, 4'hF);
    check("t1_type", bus.wr_type, 3'd2);
    bus.wr_rdy = 1'b1;
    tick();
    bus.wr_rdy = 1'b0;
    #1;
    check("t1_wait_req_low", bus.wr_req, 0);
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    #1;
    check("t1_empty", bus.empty, 1);
    check("t1_count0", bus.count, 0);
    // fill to full, drop a fifth push, drain in order
    for (int k = 0; k < 4; k++) push(32'h1FAF_F100 + 32'(16 * k), 32'hA0 + 32'(k), 4'hF, 3'd2);
    #1;
    check("t2_full", bus.full, 1);
    check("t2_in_ready", bus.in_ready, 0);
    check("t2_count", bus.count, 4);
    push(32'h1FAF_F200, 32'hDEAD, 4'hF, 3'd2);
    check("t2_drop_count", bus.count, 4);
    for (int k = 0; k < 4; k++) drain("t2_drain", 32'h1FAF_F100 + 32'(16 * k), 32'hA0 + 32'(k));
    check("t2_empty", bus.empty, 1);
    // full with pop and push in the same cycle
    for (int k = 0; k < 4; k++) push(32'h1FAF_F300 + 32'(4 * k), 32'hB0 + 32'(k), 4'hF, 3'd2);
    wait_req("t3_req", n);
    check("t3_head", bus.wr_addr, 32'h1FAF_F300);
    bus.wr_rdy = 1'b1;
    tick();
    bus.wr_rdy = 1'b0;
    bus.wr_done = 1'b1;
    bus.in_valid = 1'b1; bus.in_addr = 32'h1FAF_F3F0; bus.in_data = 32'hCC;
    #1;
    check("t3_in_ready_full", bus.in_ready, 0);
    check("t3_full_during_pop", bus.full, 1);
    tick();
    bus.wr_done = 1'b0;
    #1;
    check("t3_rejected", bus.count, 3);
    check("t3_in_ready_next", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("t3_count4", bus.count, 4);
    for (int k = 1; k < 4; k++) drain("t3_drain", 32'h1FAF_F300 + 32'(4 * k), 32'hB0 + 32'(k));
    drain("t3_wrap", 32'h1FAF_F3F0, 32'hCC);
    check("t3_empty", bus.empty, 1);
    // load hazard against a pending store
    push(32'h1FAF_F010, 32'h55, 4'hF, 3'd2);
    bus.rd_valid = 1'b1; bus.rd_addr = 32'h1FAF_F012;
    #1;
    check("t4_stall_hit", bus.rd_stall, 1);
    bus.rd_addr = 32'h1FAF_F020;
    #1;
    check("t4_stall_miss", bus.rd_stall, 0);
    bus.rd_addr = 32'h1FAF_F012;
    wait_req("t4_req", n);
    bus.wr_rdy = 1'b1;
    tick();
    bus.wr_rdy = 1'b0;
    #1;
    check("t4_stall_wait", bus.rd_stall, 1);
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    #1;
    check("t4_stall_cleared", bus.rd_stall, 0);
    bus.rd_valid = 1'b0;
    // asynchronous reset in WAIT with three entries
    for (int k = 0; k < 3; k++) push(32'h1FAF_F400 + 32'(4 * k), 32'hC0 + 32'(k), 4'hF, 3'd2);
    wait_req("t5_req", n);
    bus.wr_rdy = 1'b1;
    tick();
    bus.wr_rdy = 1'b0;
    check("t5_count3", bus.count, 3);
    #2 aresetn = 1'b0;
    #1;
    check("t5_rst_count", bus.count, 0);
    check("t5_rst_empty", bus.empty, 1);
    @(negedge aclk);
    aresetn = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | int'(bus.wr_req);
    end
    check("t5_no_replay", seen, 0);
    // asynchronous reset in REQ drops wr_req at once
    push(32'h1FAF_F500, 32'h77, 4'hF, 3'd2);
    wait_req("t5b_req", n);
    #2 aresetn = 1'b0;
    #1;
    check("t5b_req_drop", bus.wr_req, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    // byte stores to one word behind a busy head
    push(32'h1FAF_F100, 32'h1, 4'hF, 3'd2);
    wait_req("t6_req", n);
    push(32'h1FAF_F004, 32'h0000_00AA, 4'b0001, 3'd0);
    push(32'h1FAF_F005, 32'h0000_BB00, 4'b0010, 3'd0);
    #1;
`ifdef UNCACHE_WB_MERGE_EN
    check("t6_count", bus.count, 2);
`else
    check("t6_count", bus.count, 3);
`endif
    drain("t6_head", 32'h1FAF_F100, 32'h1);
    wait_req("t6_req2", n);
    check("t6_addr", bus.wr_addr, 32'h1FAF_F004);
`ifdef UNCACHE_WB_MERGE_EN
    check("t6_wstrb", bus.wr_wstrb, 4'b0011);
    check("t6_data", bus.wr_data, 32'h0000_BBAA);
    check("t6_type", bus.wr_type, 3'b010);
    handshake();
`else
    check("t6_wstrb", bus.wr_wstrb, 4'b0001);
    check("t6_data", bus.wr_data, 32'h0000_00AA);
    check("t6_type", bus.wr_type, 3'd0);
    handshake();
    drain("t6_second", 32'h1FAF_F005, 32'h0000_BB00);
`endif
    check("t6_empty", bus.empty, 1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
